alu_mode_controller: RTL and testbench

Synchronous front-end controller for the 8-bit arithmetic/logical/comparison processor. It debounces the two push-buttons and cycles the module select on KEY[0]. On KEY[1] it latches sub-op and operand from the switches, waits a settle window, and captures the selected block's result into a hold register. It sits between the board I/O and the datapath blocks and replaces the button-clocked select register.

---
 rtl/alu_mode_controller_pkg.sv | 40 ++++
 rtl/alu_mode_controller_key_debounce.sv | 56 +++++
 rtl/alu_mode_controller.sv | 145 ++++++++++++++
 tb/tb_alu_mode_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mode_controller_pkg.sv
// Shared encodings for the ALU front-end controller.
// Latency: n/a (constants, types and one combinational helper).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam int RES_W = 10;

    localparam logic [1:0] MODE_ARITH = 2'd0;
    localparam logic [1:0] MODE_LOGIC = 2'd1;
    localparam logic [1:0] MODE_CMP   = 2'd2;
    localparam logic [1:0] MODE_MAGIC = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } ctrl_state_t;

    // Packs the selected datapath block's outputs into the 10-bit hold format.
    // Bit 8 of the arithmetic format is deliberately zero so the carry sits on
    // bit 9 next to the 8-bit sum.
    function automatic logic [RES_W-1:0] capture_result(
        input logic [1:0] mode,
        input logic [7:0] arith_res,
        input logic       arith_carry,
        input logic [9:0] logic_res,
        input logic [3:0] cmp_res
    );
        logic [RES_W-1:0] res;
        case (mode)
            MODE_ARITH: res = {arith_carry, 1'b0, arith_res};
            MODE_LOGIC: res = logic_res;
            MODE_CMP:   res = {6'b0, cmp_res};
            default:    res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_mode_controller_key_debounce.sv
// Push-button debouncer: 2-flop sync, stability counter, one-cycle press pulse.
// Latency: press_o high DEBOUNCE_CYCLES+2 edges after a clean key fall is sampled.
// Backpressure: none; a release or a glitch shorter than DEBOUNCE_CYCLES never pulses.
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset (debounced level returns to released)
//   key_i    raw active-low key
//   press_o  one-cycle pulse on an accepted released->pressed transition
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Sync flops reset to "released" so a key held through reset is seen as a
    // fresh press once reset lifts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            meta_q  <= key_i;
            sync_q  <= meta_q;
            press_q <= 1'b0;
            if (sync_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q;
                cnt_q    <= '0;
                // Only the 1->0 (press) direction produces a pulse.
                press_q  <= ~sync_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_mode_controller.sv
// Board front-end: debounced module select cycling and latch/settle/capture sequencing.
// Latency: mode change DEBOUNCE_CYCLES+3 edges after KEY[0] falls; result 1+SETTLE_CYCLES edges after LATCH entry.
// Backpressure: key presses arriving in LATCH/SETTLE are dropped, not queued.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   KEY[1:0]                 raw active-low buttons: [0] next module, [1] execute
//   SW[9:0]                  raw switches: [9:8] sub-op, [7:0] operand
//   arith_res/arith_carry    arithmetic block outputs
//   logic_res, cmp_res       logical / comparison block outputs
//   module_select            0 arith, 1 logic, 2 compare, 3 magic
//   op_sel, operand          switch values latched in LATCH, drive the datapath
//   busy                     high in LATCH and SETTLE
//   result_valid/result_hold captured result and its valid flag
module alu_mode_controller
    import alu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SETTLE_CYCLES   = 2,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [7:0]       arith_res,
    input  logic             arith_carry,
    input  logic [9:0]       logic_res,
    input  logic [3:0]       cmp_res,
    output logic [1:0]       module_select,
    output logic [1:0]       op_sel,
    output logic [7:0]       operand,
    output logic             busy,
    output logic             result_valid,
    output logic [RES_W-1:0] result_hold
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    logic mode_press;
    logic exec_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key_mode (
        .clk_i  (CLK),
        .rst_i  (RST),
        .key_i  (KEY[0]),
        .press_o(mode_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key_exec (
        .clk_i  (CLK),
        .rst_i  (RST),
        .key_i  (KEY[1]),
        .press_o(exec_press)
    );

    ctrl_state_t      state_q,  state_d;
    logic [1:0]       mode_q,   mode_d;
    logic [1:0]       op_q,     op_d;
    logic [7:0]       opnd_q,   opnd_d;
    logic             rv_q,     rv_d;
    logic [RES_W-1:0] hold_q,   hold_d;
    logic [SC_W-1:0]  scnt_q,   scnt_d;

    logic exec_go;

    // Execute in magic mode is treated as if the key was never pressed, so a
    // coincident mode press still advances the select in that case.
    assign exec_go = exec_press && (mode_q != MODE_MAGIC);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        rv_d    = rv_q;
        hold_d  = hold_q;
        scnt_d  = scnt_q;
        case (state_q)
            IDLE, HOLD: begin
                // Execute has priority; the mode pulse is dropped if both fire.
                if (exec_go) begin
                    state_d = LATCH;
                end else if (mode_press) begin
                    mode_d  = mode_q + 2'd1;
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            LATCH: begin
                op_d    = SW[9:8];
                opnd_d  = SW[7:0];
                rv_d    = 1'b0;
                scnt_d  = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (scnt_q == SETTLE_LAST) begin
                    hold_d  = capture_result(mode_q, arith_res, arith_carry,
                                             logic_res, cmp_res);
                    rv_d    = 1'b1;
                    state_d = HOLD;
                end else begin
                    scnt_d = scnt_q + SC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            mode_q  <= MODE_ARITH;
            op_q    <= '0;
            opnd_q  <= '0;
            rv_q    <= 1'b0;
            hold_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            rv_q    <= rv_d;
            hold_q  <= hold_d;
            scnt_q  <= scnt_d;
        end
    end

    assign module_select = mode_q;
    assign op_sel        = op_q;
    assign operand       = opnd_q;
    assign busy          = (state_q == LATCH) || (state_q == SETTLE);
    assign result_valid  = rv_q;
    assign result_hold   = hold_q;

endmodule

// File: tb/tb_alu_mode_controller.sv
// Directed bench for alu_mode_controller with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_alu_mode_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic [7:0] arith_res;
    logic       arith_carry;
    logic [9:0] logic_res;
    logic [3:0] cmp_res;
    logic [1:0] module_select;
    logic [1:0] op_sel;
    logic [7:0] operand;
    logic       busy;
    logic       result_valid;
    logic [9:0] result_hold;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mode_controller #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (2),
        .CNT_W          (16)
    ) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .KEY          (KEY),
        .SW           (SW),
        .arith_res    (arith_res),
        .arith_carry  (arith_carry),
        .logic_res    (logic_res),
        .cmp_res      (cmp_res),
        .module_select(module_select),
        .op_sel       (op_sel),
        .operand      (operand),
        .busy         (busy),
        .result_valid (result_valid),
        .result_hold  (result_hold)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Clean KEY[0] press and release, long enough to debounce both edges.
    task automatic press_mode();
        @(negedge CLK) KEY[0] = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK) KEY[0] = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
    endtask

    // Press KEY[1] (optionally together with KEY[0]) and watch until busy has
    // come and gone with result_valid high, or the cycle budget runs out.
    task automatic exec_run(input bit with_mode, output int busy_cnt, output bit done);
        busy_cnt = 0;
        done     = 1'b0;
        @(negedge CLK) KEY = with_mode ? 2'b00 : 2'b01;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge CLK);
            #1;
            if (busy) busy_cnt++;
            else if (busy_cnt > 0 && result_valid) done = 1'b1;
        end
        @(negedge CLK) KEY = 2'b11;
        repeat (10) @(posedge CLK);
        #1;
    endtask

    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] prev_mode;
    int  bcnt;
    bit  done;
    int  rises;
    bit  seen;
    logic busy_prev;

    initial begin
        RST = 1'b1; KEY = 2'b11; SW = '0;
        arith_res = '0; arith_carry = 1'b0; logic_res = '0; cmp_res = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        cycles(1);
        chk("rst_module_select", 10'(module_select), 10'd0);
        chk("rst_op_sel",        10'(op_sel),        10'd0);
        chk("rst_operand",       10'(operand),       10'd0);
        chk("rst_busy",          10'(busy),          10'd0);
        chk("rst_result_valid",  10'(result_valid),  10'd0);
        chk("rst_result_hold",   result_hold,        10'd0);

        // Mode wrap: change lands exactly 7 edges after KEY[0] falls.
        for (int i = 0; i < 5; i++) begin
            prev_mode = (i == 0) ? 2'd0 : wrap_exp[i-1];
            @(negedge CLK) KEY[0] = 1'b0;
            cycles(6);
            chk("wrap_before", 10'(module_select), 10'(prev_mode));
            cycles(1);
            chk("wrap_after", 10'(module_select), 10'(wrap_exp[i]));
            repeat (3) @(posedge CLK);
            @(negedge CLK) KEY[0] = 1'b1;
            cycles(10);
        end

        // Bounce: 2-low/2-high for 20 cycles never reaches 4 stable cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK) KEY[0] = 1'b0;
            repeat (2) @(negedge CLK);
            KEY[0] = 1'b1;
            repeat (1) @(negedge CLK);
        end
        cycles(15);
        chk("bounce_module_select", 10'(module_select), 10'd1);

        // Back to arithmetic: 1 -> 2 -> 3 -> 0.
        press_mode(); press_mode(); press_mode();
        chk("to_arith", 10'(module_select), 10'd0);

        SW = 10'b01_1111_0000; arith_res = 8'hA5; arith_carry = 1'b1;
        exec_run(1'b0, bcnt, done);
        chk("arith_done",     10'(done),         10'd1);
        chk("arith_busy_len", 10'(bcnt),         10'd3);
        chk("arith_op_sel",   10'(op_sel),       10'd1);
        chk("arith_operand",  10'(operand),      10'hF0);
        chk("arith_hold",     result_hold,       10'h2A5);
        chk("arith_valid",    10'(result_valid), 10'd1);

        // Switches outside LATCH must not reach op_sel/operand.
        SW = 10'h3FF;
        cycles(5);
        chk("sw_ignored_op",  10'(op_sel),  10'd1);
        chk("sw_ignored_opd", 10'(operand), 10'hF0);

        // KEY[0] pulse lands in SETTLE (2 cycles behind KEY[1]) and is dropped.
        arith_res = 8'h3C; arith_carry = 1'b0;
        @(negedge CLK) KEY[1] = 1'b0;
        repeat (2) @(negedge CLK);
        KEY[0] = 1'b0;
        cycles(20);
        chk("lockout_module_select", 10'(module_select), 10'd0);
        chk("lockout_hold",          result_hold,        10'h03C);
        chk("lockout_valid",         10'(result_valid),  10'd1);
        chk("lockout_op_sel",        10'(op_sel),        10'd3);
        @(negedge CLK) KEY = 2'b11;
        cycles(10);

        // Mode press in HOLD clears result_valid.
        press_mode();
        chk("hold_mode_sel",   10'(module_select), 10'd1);
        chk("hold_mode_valid", 10'(result_valid),  10'd0);

        logic_res = 10'h3C3;
        exec_run(1'b0, bcnt, done);
        chk("logic_hold", result_hold, 10'h3C3);

        // Simultaneous presses in HOLD: execute wins.
        exec_run(1'b1, bcnt, done);
        chk("simul_done",          10'(done),          10'd1);
        chk("simul_module_select", 10'(module_select), 10'd1);
        chk("simul_hold",          result_hold,        10'h3C3);
        chk("simul_valid",         10'(result_valid),  10'd1);

        // Compare mode capture.
        press_mode();
        cmp_res = 4'hA;
        exec_run(1'b0, bcnt, done);
        chk("cmp_hold", result_hold, 10'h00A);

        // Magic mode: execute ignored entirely.
        press_mode();
        chk("magic_sel",   10'(module_select), 10'd3);
        chk("magic_valid", 10'(result_valid),  10'd0);
        SW = 10'h000;
        exec_run(1'b0, bcnt, done);
        chk("magic_busy",    10'(bcnt),          10'd0);
        chk("magic_valid2",  10'(result_valid),  10'd0);
        chk("magic_op_sel",  10'(op_sel),        10'd3);
        chk("magic_sel2",    10'(module_select), 10'd3);

        // Reset mid-SETTLE with KEY[1] held through reset.
        press_mode();
        chk("wrap_to_arith", 10'(module_select), 10'd0);
        SW = 10'b10_0101_0101; arith_res = 8'h5A; arith_carry = 1'b0;
        @(negedge CLK) KEY[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge CLK);
            #1;
            if (busy) seen = 1'b1;
        end
        chk("busy_wait", 10'(seen), 10'd1);
        @(posedge CLK);
        @(negedge CLK) RST = 1'b1;
        cycles(1);
        chk("midrst_module_select", 10'(module_select), 10'd0);
        chk("midrst_op_sel",        10'(op_sel),        10'd0);
        chk("midrst_operand",       10'(operand),       10'd0);
        chk("midrst_busy",          10'(busy),          10'd0);
        chk("midrst_valid",         10'(result_valid),  10'd0);
        chk("midrst_hold",          result_hold,        10'd0);
        @(negedge CLK) RST = 1'b0;
        rises = 0;
        busy_prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (busy && !busy_prev) rises++;
            busy_prev = busy;
        end
        chk("held_key_exec_count", 10'(rises),        10'd1);
        chk("held_key_valid",      10'(result_valid), 10'd1);
        chk("held_key_hold",       result_hold,       10'h05A);
        chk("held_key_op_sel",     10'(op_sel),       10'd2);
        chk("held_key_operand",    10'(operand),      10'h55);
        @(negedge CLK) KEY = 2'b11;
        cycles(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
